// File: rtl/stack_unit.sv
// stack_unit: register-based LIFO stack for the datapath push/pop instructions.
// Storage is a circular array addressed by a base (bottom) pointer and a
// write pointer (one past the top). Outputs are all registered or decoded
// from registered state, so there is no input-to-output combinational path.
module stack_unit #(
    parameter int  DATA_WIDTH = 16,
    parameter int  DEPTH      = 8,
    parameter int  FULL_MODE  = 0,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] pushData,
    input  logic                  clearErr,
    output logic [DATA_WIDTH-1:0] topData,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] L_LAST  = PTR_W'(DEPTH - 1);

    // Storage and control state
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_base;
    logic [PTR_W-1:0]      r_wrPtr;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_top;
    logic                  r_ovf;
    logic                  r_unf;

    // Next-state signals
    logic [PTR_W-1:0]      w_baseNext;
    logic [PTR_W-1:0]      w_wrPtrNext;
    logic [CNT_W-1:0]      w_cntNext;
    logic [DATA_WIDTH-1:0] w_topNext;
    logic                  w_memWe;
    logic [PTR_W-1:0]      w_memIdx;
    logic                  w_setOvf;
    logic                  w_setUnf;
    logic                  w_empty;
    logic                  w_full;
    logic [PTR_W-1:0]      w_topIdx;
    logic [PTR_W-1:0]      w_belowIdx;

    // Modulo-DEPTH pointer step; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
        return (p == L_LAST) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptrDec(input logic [PTR_W-1:0] p);
        return (p == '0) ? L_LAST : p - 1'b1;
    endfunction

    // Status decoded from registered count only.
    assign w_empty    = (r_cnt == '0);
    assign w_full     = (r_cnt == L_DEPTH);
    assign w_topIdx   = ptrDec(r_wrPtr);
    assign w_belowIdx = ptrDec(w_topIdx);

    // Op decode: computes pointer/count/top updates and the storage write.
    always_comb begin
        w_baseNext  = r_base;
        w_wrPtrNext = r_wrPtr;
        w_cntNext   = r_cnt;
        w_topNext   = r_top;
        w_memWe     = 1'b0;
        w_memIdx    = r_wrPtr;
        w_setOvf    = 1'b0;
        w_setUnf    = 1'b0;

        if (push && pop && !w_empty) begin
            // Replace the top in place; count and pointers unchanged.
            w_memWe   = 1'b1;
            w_memIdx  = w_topIdx;
            w_topNext = pushData;
        end else if (push) begin
            // Covers push+pop on an empty stack, which acts as a plain push.
            if (!w_full) begin
                w_memWe     = 1'b1;
                w_memIdx    = r_wrPtr;
                w_wrPtrNext = ptrInc(r_wrPtr);
                w_cntNext   = r_cnt + 1'b1;
                w_topNext   = pushData;
            end else begin
                w_setOvf = 1'b1;
                if (FULL_MODE != 0) begin
                    // When full, the write slot is the bottom entry: overwrite
                    // it and advance the base so the oldest entry drops out.
                    w_memWe     = 1'b1;
                    w_memIdx    = r_wrPtr;
                    w_wrPtrNext = ptrInc(r_wrPtr);
                    w_baseNext  = ptrInc(r_base);
                    w_topNext   = pushData;
                end
            end
        end else if (pop) begin
            if (!w_empty) begin
                w_wrPtrNext = w_topIdx;
                w_cntNext   = r_cnt - 1'b1;
                w_topNext   = (r_cnt == CNT_W'(1)) ? '0 : r_mem[w_belowIdx];
            end else begin
                w_setUnf = 1'b1;
            end
        end
    end

    // Control state with asynchronous active-low reset; a new error beats clearErr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base  <= '0;
            r_wrPtr <= '0;
            r_cnt   <= '0;
            r_top   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_base  <= w_baseNext;
            r_wrPtr <= w_wrPtrNext;
            r_cnt   <= w_cntNext;
            r_top   <= w_topNext;
            r_ovf   <= (r_ovf & ~clearErr) | w_setOvf;
            r_unf   <= (r_unf & ~clearErr) | w_setUnf;
        end
    end

    // Entry storage, not reset; writes are suppressed while reset is held.
    always_ff @(posedge clk) begin
        if (reset && w_memWe) begin
            r_mem[w_memIdx] <= pushData;
        end
    end

    assign topData   = r_top;
    assign count     = r_cnt;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule

// File: tb/tb_stack_unit.sv
// Directed testbench for stack_unit: two DEPTH=4 instances share the inputs,
// one rejecting pushes when full and one discarding the oldest entry.
module tb_stack_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [15:0] pushData = '0;
    logic        clearErr = 1'b0;

    logic [15:0] r_top, c_top;
    logic [2:0]  r_cnt, c_cnt;
    logic        r_empty, r_full, r_ovf, r_unf;
    logic        c_empty, c_full, c_ovf, c_unf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    stack_unit #(.DATA_WIDTH(16), .DEPTH(4), .FULL_MODE(0)) u_rej (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .pushData(pushData),
        .clearErr(clearErr), .topData(r_top), .count(r_cnt), .empty(r_empty),
        .full(r_full), .overflow(r_ovf), .underflow(r_unf)
    );

    stack_unit #(.DATA_WIDTH(16), .DEPTH(4), .FULL_MODE(1)) u_circ (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .pushData(pushData),
        .clearErr(clearErr), .topData(c_top), .count(c_cnt), .empty(c_empty),
        .full(c_full), .overflow(c_ovf), .underflow(c_unf)
    );

    // One clocked operation; outputs are valid 1 time unit after the edge.
    task automatic op(input logic pu, input logic po, input logic [15:0] d, input logic ce);
        push = pu; pop = po; pushData = d; clearErr = ce;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clearErr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({r_cnt, r_empty, r_full, r_top, r_ovf, r_unf} !== {3'd0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_init: cnt=%0d empty=%b full=%b top=%h ovf=%b unf=%b, want 0 1 0 0000 0 0",
                     r_cnt, r_empty, r_full, r_top, r_ovf, r_unf);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        op(1'b0, 1'b1, 16'h0, 1'b0);
        op(1'b1, 1'b0, 16'h0011, 1'b0);
        op(1'b1, 1'b0, 16'h0022, 1'b0);
        op(1'b1, 1'b0, 16'h0033, 1'b0);
        n_checks++;
        if (r_cnt !== 3'd3 || r_top !== 16'h0033 || r_unf !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_prefill: cnt=%0d top=%h unf=%b, want 3 0033 1", r_cnt, r_top, r_unf);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({r_cnt, r_empty, r_full, r_top, r_ovf, r_unf} !== {3'd0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_midstream: cnt=%0d empty=%b full=%b top=%h ovf=%b unf=%b, want 0 1 0 0000 0 0",
                     r_cnt, r_empty, r_full, r_top, r_ovf, r_unf);
        end
        reset = 1'b1;
        op(1'b1, 1'b0, 16'h8060, 1'b0);
        n_checks++;
        if (r_top !== 16'h8060 || r_cnt !== 3'd1 || r_empty !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release_push: top=%h cnt=%0d empty=%b, want 8060 1 0", r_top, r_cnt, r_empty);
        end
    endtask

    task automatic test_fill_drain();
        logic [15:0] exp_pop [4];
        exp_pop = '{16'd3, 16'd2, 16'd1, 16'd0};
        do_reset();
        for (int i = 1; i <= 4; i++) op(1'b1, 1'b0, 16'(i), 1'b0);
        n_checks++;
        if (r_full !== 1'b1 || r_top !== 16'd4 || r_cnt !== 3'd4) begin
            n_errors++;
            $display("FAIL fill: full=%b top=%h cnt=%0d, want 1 0004 4", r_full, r_top, r_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 1'b1, 16'h0, 1'b0);
            n_checks++;
            if (r_top !== exp_pop[i] || r_cnt !== 3'(3 - i)) begin
                n_errors++;
                $display("FAIL drain_%0d: top=%h cnt=%0d, want %h %0d", i, r_top, r_cnt, exp_pop[i], 3 - i);
            end
        end
        n_checks++;
        if (r_empty !== 1'b1 || r_full !== 1'b0 || r_unf !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_empty: empty=%b full=%b unf=%b, want 1 0 0", r_empty, r_full, r_unf);
        end
        op(1'b0, 1'b1, 16'h0, 1'b0);
        n_checks++;
        if (r_unf !== 1'b1 || r_cnt !== 3'd0 || r_top !== 16'h0) begin
            n_errors++;
            $display("FAIL pop_empty: unf=%b cnt=%0d top=%h, want 1 0 0000", r_unf, r_cnt, r_top);
        end
    endtask

    task automatic test_overflow_reject();
        logic [15:0] exp_pop [4];
        exp_pop = '{16'd3, 16'd2, 16'd1, 16'd0};
        do_reset();
        for (int i = 1; i <= 5; i++) op(1'b1, 1'b0, 16'(i), 1'b0);
        n_checks++;
        if (r_ovf !== 1'b1 || r_top !== 16'd4 || r_cnt !== 3'd4) begin
            n_errors++;
            $display("FAIL ovf_reject: ovf=%b top=%h cnt=%0d, want 1 0004 4", r_ovf, r_top, r_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 1'b1, 16'h0, 1'b0);
            n_checks++;
            if (r_top !== exp_pop[i]) begin
                n_errors++;
                $display("FAIL ovf_drain_%0d: top=%h, want %h", i, r_top, exp_pop[i]);
            end
        end
    endtask

    task automatic test_circular();
        logic [15:0] exp_pop [4];
        exp_pop = '{16'd5, 16'd4, 16'd3, 16'd0};
        do_reset();
        for (int i = 1; i <= 6; i++) op(1'b1, 1'b0, 16'(i), 1'b0);
        n_checks++;
        if (c_cnt !== 3'd4 || c_ovf !== 1'b1 || c_top !== 16'd6 || c_full !== 1'b1) begin
            n_errors++;
            $display("FAIL circ_fill: cnt=%0d ovf=%b top=%h full=%b, want 4 1 0006 1", c_cnt, c_ovf, c_top, c_full);
        end
        for (int i = 0; i < 4; i++) begin
            op(1'b0, 1'b1, 16'h0, 1'b0);
            n_checks++;
            if (c_top !== exp_pop[i]) begin
                n_errors++;
                $display("FAIL circ_drain_%0d: top=%h, want %h", i, c_top, exp_pop[i]);
            end
        end
        n_checks++;
        if (c_empty !== 1'b1 || c_cnt !== 3'd0 || c_unf !== 1'b0) begin
            n_errors++;
            $display("FAIL circ_empty: empty=%b cnt=%0d unf=%b, want 1 0 0", c_empty, c_cnt, c_unf);
        end
        // Pointers are now mid-array; a push/pop pair must still work after wrap.
        op(1'b1, 1'b0, 16'h0A0A, 1'b0);
        op(1'b1, 1'b0, 16'h0B0B, 1'b0);
        op(1'b0, 1'b1, 16'h0, 1'b0);
        n_checks++;
        if (c_top !== 16'h0A0A || c_cnt !== 3'd1) begin
            n_errors++;
            $display("FAIL circ_wrap: top=%h cnt=%0d, want 0a0a 1", c_top, c_cnt);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        op(1'b1, 1'b0, 16'h1111, 1'b0);
        op(1'b1, 1'b0, 16'h2222, 1'b0);
        op(1'b1, 1'b1, 16'h3F01, 1'b0);
        n_checks++;
        if (r_cnt !== 3'd2 || r_top !== 16'h3F01) begin
            n_errors++;
            $display("FAIL pushpop_replace: cnt=%0d top=%h, want 2 3f01", r_cnt, r_top);
        end
        op(1'b0, 1'b1, 16'h0, 1'b0);
        n_checks++;
        if (r_top !== 16'h1111 || r_cnt !== 3'd1) begin
            n_errors++;
            $display("FAIL pushpop_below: top=%h cnt=%0d, want 1111 1", r_top, r_cnt);
        end
        op(1'b0, 1'b1, 16'h0, 1'b0);
        op(1'b1, 1'b1, 16'hC00C, 1'b0);
        n_checks++;
        if (r_cnt !== 3'd1 || r_top !== 16'hC00C || r_unf !== 1'b0) begin
            n_errors++;
            $display("FAIL pushpop_empty: cnt=%0d top=%h unf=%b, want 1 c00c 0", r_cnt, r_top, r_unf);
        end
        for (int i = 2; i <= 4; i++) op(1'b1, 1'b0, 16'(i), 1'b0);
        op(1'b1, 1'b1, 16'h9999, 1'b0);
        n_checks++;
        if (r_cnt !== 3'd4 || r_top !== 16'h9999 || r_ovf !== 1'b0 || c_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL pushpop_full: cnt=%0d top=%h ovf=%b/%b, want 4 9999 0/0", r_cnt, r_top, r_ovf, c_ovf);
        end
        op(1'b0, 1'b1, 16'h0, 1'b0);
        n_checks++;
        if (r_top !== 16'd3) begin
            n_errors++;
            $display("FAIL pushpop_full_pop: top=%h, want 0003", r_top);
        end
    endtask

    task automatic test_sticky_clear();
        do_reset();
        op(1'b0, 1'b1, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            op(1'b0, 1'b0, 16'h0, 1'b0);
            n_checks++;
            if (r_unf !== 1'b1) begin
                n_errors++;
                $display("FAIL unf_sticky_%0d: unf=%b, want 1", i, r_unf);
            end
        end
        op(1'b0, 1'b0, 16'h0, 1'b1);
        n_checks++;
        if (r_unf !== 1'b0) begin
            n_errors++;
            $display("FAIL unf_clear: unf=%b, want 0", r_unf);
        end
        op(1'b0, 1'b1, 16'h0, 1'b1);
        n_checks++;
        if (r_unf !== 1'b1) begin
            n_errors++;
            $display("FAIL unf_clear_vs_set: unf=%b, want 1", r_unf);
        end
        for (int i = 1; i <= 5; i++) op(1'b1, 1'b0, 16'(i), 1'b0);
        op(1'b0, 1'b0, 16'h0, 1'b1);
        n_checks++;
        if (r_ovf !== 1'b0 || c_ovf !== 1'b0 || r_unf !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_clear: ovf=%b/%b unf=%b, want 0/0 0", r_ovf, c_ovf, r_unf);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_reject();
        test_circular();
        test_simultaneous();
        test_sticky_clear();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
